// File: rtl/code_lock_2b.sv
// code_lock_2b
//   Sequential code-entry lock fed by a stream of 2-bit symbols.
//   Every attempt collects exactly CODE_LEN symbols before it is judged, so a
//   wrong attempt does not reveal which symbol was wrong. A correct attempt
//   opens the lock for OPEN_CYCLES clocks. MAX_FAILS consecutive wrong
//   attempts cause a lockout lasting LOCKOUT_CYCLES clocks.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sym_valid  in   symbol strobe, one symbol accepted per cycle
//   sym[1:0]   in   symbol value, sampled when sym_valid=1
//   clear      in   abort the current entry; from OPEN, relock early
//   unlocked   out  high while in OPEN
//   fail       out  one-cycle pulse per wrong attempt
//   locked_out out  high while in LOCKOUT
//   progress   out  symbols accepted in the current attempt
//   fail_cnt   out  consecutive failed attempts (saturates at MAX_FAILS)
module code_lock_2b #(
  parameter int unsigned               CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0]     CODE           = 8'b10_01_11_00,
  parameter int unsigned               MAX_FAILS      = 3,
  parameter int unsigned               OPEN_CYCLES    = 8,
  parameter int unsigned               LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  input  logic       clear,
  output logic       unlocked,
  output logic       fail,
  output logic       locked_out,
  output logic [2:0] progress,
  output logic [3:0] fail_cnt
);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  state_e     state_q,    state_d;
  logic [2:0] progress_q, progress_d;
  logic       mismatch_q, mismatch_d;
  logic       fail_q,     fail_d;
  logic [3:0] fail_cnt_q, fail_cnt_d;
  logic [7:0] timer_q,    timer_d;

  logic [1:0] exp_sym;
  logic       sym_bad;
  logic [3:0] fail_cnt_inc;

  // Expected symbol for the slot currently being entered; slot 0 is the
  // most significant symbol of CODE.
  always_comb begin
    exp_sym = 2'b00;
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (progress_q == 3'(i)) exp_sym = CODE[2*(int'(CODE_LEN)-1-i) +: 2];
    end
  end

  assign sym_bad      = (sym != exp_sym);
  assign fail_cnt_inc = (fail_cnt_q == 4'(MAX_FAILS)) ? fail_cnt_q : fail_cnt_q + 4'd1;

  // NOTE: every signal assigned in this block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    mismatch_d = mismatch_q;
    fail_d     = 1'b0;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;

    unique case (state_q)
      ENTRY: begin
        if (clear) begin
          progress_d = 3'd0;
          mismatch_d = 1'b0;
        end else if (sym_valid) begin
          if (progress_q == 3'(CODE_LEN - 1)) begin
            // Last symbol: judge the whole attempt, including this symbol.
            progress_d = 3'd0;
            mismatch_d = 1'b0;
            if (mismatch_q || sym_bad) begin
              fail_d     = 1'b1;
              fail_cnt_d = fail_cnt_inc;
              if (fail_cnt_inc == 4'(MAX_FAILS)) begin
                state_d = LOCKOUT;
                timer_d = 8'(LOCKOUT_CYCLES - 1);
              end
            end else begin
              state_d    = OPEN;
              fail_cnt_d = 4'd0;
              timer_d    = 8'(OPEN_CYCLES - 1);
            end
          end else begin
            progress_d = progress_q + 3'd1;
            mismatch_d = mismatch_q | sym_bad;
          end
        end
      end

      OPEN: begin
        if (clear || timer_q == 8'd0) begin
          state_d = ENTRY;
          timer_d = 8'd0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      LOCKOUT: begin
        if (timer_q == 8'd0) begin
          state_d    = ENTRY;
          fail_cnt_d = 4'd0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      default: begin
        state_d    = ENTRY;
        progress_d = 3'd0;
        mismatch_d = 1'b0;
        timer_d    = 8'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ENTRY;
      progress_q <= 3'd0;
      mismatch_q <= 1'b0;
      fail_q     <= 1'b0;
      fail_cnt_q <= 4'd0;
      timer_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
    end
  end

  // Outputs are decoded from registers only; no input reaches them
  // combinationally.
  assign unlocked   = (state_q == OPEN);
  assign locked_out = (state_q == LOCKOUT);
  assign fail       = fail_q;
  assign progress   = progress_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: doc/code_lock_2b.md
Name: code_lock_2b

Overview:
- Sequential code-entry lock that consumes a stream of 2-bit symbols.
- Compares each accepted symbol against one slot of a stored code, using 2-bit equality per symbol.
- Opens for a timed window on a full correct sequence.
- Counts failed attempts and enters a timed lockout after too many failures.
- Sits downstream of the keypad/switch debouncer and feeds the door/indicator logic.

Parameters:
- CODE_LEN, 4, number of 2-bit symbols per attempt (1..8).
- CODE, 8'b10_01_11_00, stored code; first symbol entered is CODE[2*CODE_LEN-1 -: 2], last is CODE[1:0].
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..15).
- OPEN_CYCLES, 8, clock cycles unlocked stays high (1..255).
- LOCKOUT_CYCLES, 16, clock cycles the lockout lasts (1..255).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- sym_valid  input  1  symbol strobe; one symbol is accepted per cycle when high.
- sym  input  2  symbol value, sampled when sym_valid=1.
- clear  input  1  aborts the current entry; from OPEN, relocks early.
- unlocked  output  1  high while in OPEN.
- fail  output  1  one-cycle pulse on each wrong attempt.
- locked_out  output  1  high while in LOCKOUT.
- progress  output  3  count of symbols accepted in the current attempt.
- fail_cnt  output  4  consecutive failed attempts.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n); it is applied asynchronously and its deassertion is synchronous to clk.
- Reset values:
  - unlocked=0, fail=0, locked_out=0, progress=0, fail_cnt=0.
  - State ENTRY, mismatch flag cleared, timer=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: ENTRY, OPEN, LOCKOUT.
- ENTRY:
  - A symbol is accepted on a rising edge with sym_valid=1 and clear=0.
  - Each accepted symbol is compared to the slot indexed by progress. On inequality, the sticky mismatch flag is set.
  - A mismatch does not abort the attempt: all CODE_LEN symbols are always collected, so the point of failure is not revealed.
  - Accepting symbol k<CODE_LEN-1: progress increments.
  - Accepting the last symbol (progress==CODE_LEN-1), resolved on that same edge:
    - If there is no mismatch in any slot: go to OPEN, unlocked=1 from the next cycle, fail_cnt=0, timer=OPEN_CYCLES-1.
    - If there is a mismatch: fail=1 for exactly one cycle and fail_cnt increments.
      - If the new fail_cnt==MAX_FAILS: go to LOCKOUT, locked_out=1 from the next cycle, timer=LOCKOUT_CYCLES-1.
      - Otherwise stay in ENTRY.
    - In every case, progress=0 and the mismatch flag is cleared.
  - clear=1 (priority over sym_valid on the same edge): progress=0, mismatch cleared, fail_cnt unchanged, no fail pulse.
- OPEN:
  - sym_valid is ignored.
  - The timer decrements each cycle. At timer==0, or on clear=1, go to ENTRY and unlocked=0 on the next cycle.
  - unlocked is high for exactly OPEN_CYCLES cycles when clear is not used.
- LOCKOUT:
  - sym_valid and clear are ignored.
  - The timer decrements. At timer==0, go to ENTRY with fail_cnt=0.
  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
- fail_cnt saturates at MAX_FAILS and never wraps.
- A reset mid-attempt, mid-OPEN or mid-LOCKOUT immediately forces the reset values; no partial state survives.
- sym is don't-care when sym_valid=0. Back-to-back valid cycles are legal.

Test Plan:
- Reset, then 10,01,11,00 on 4 consecutive valid cycles -> unlocked=1 on the cycle after the 4th edge, held 8 cycles, then 0. fail never asserts. fail_cnt=0.
- Reset, then enter 10,01,11,01 -> one-cycle fail pulse after the 4th edge. fail_cnt=1, progress=0, unlocked stays 0. Then enter the correct code -> unlocked=1 and fail_cnt=0.
- First symbol wrong (00,01,11,00) -> no reaction until the 4th symbol, progress counts 1,2,3,0, then fail pulse.
- Three consecutive wrong attempts -> fail_cnt=3 and locked_out=1 for 16 cycles. The correct code entered during lockout is ignored (unlocked=0). Then locked_out=0, fail_cnt=0, and the correct code opens.
- Enter 10,01, then clear=1 together with sym_valid=1 -> progress=0, no fail pulse, fail_cnt unchanged. A full correct entry afterwards opens. clear=1 on the 3rd OPEN cycle -> unlocked=0 on the next cycle.
- Assert rst_n=0 asynchronously between clock edges during OPEN and during LOCKOUT -> all outputs go to 0 immediately, without waiting for a clock edge.
